dmem_arbiter: RTL

Two-port arbiter that shares the single data memory port between the riscv core's data interface (m0) and a debug/loader master (m1). It sits between the core and data_mem. It grants at most one access per cycle. The core has fixed priority, but a burst counter bounds how long the debug master can be starved. Read data returns through a registered response path one cycle after grant.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_arb_stats.sv | 35 +++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter.
// Owner encoding, default burst bound and starve counter width.
package dmem_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  localparam int MAX_BURST_DEF = 4;
  localparam int STARVE_W      = 8;

endpackage

// File: rtl/dmem_arb_stats.sv
// Grant and conflict counters for the data-memory arbiter.
// Built only when DMEM_ARB_STATS_EN is defined; counters wrap mod 2^32.
module dmem_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m0_gnt,
  input  logic        i_m1_gnt,
  input  logic        i_conflict,
  output logic [31:0] o_m0_grants,
  output logic [31:0] o_m1_grants,
  output logic [31:0] o_conflicts
);

  logic [31:0] r_m0_grants;
  logic [31:0] r_m1_grants;
  logic [31:0] r_conflicts;

  // Count grants per master and cycles with both masters requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_grants <= '0;
      r_m1_grants <= '0;
      r_conflicts <= '0;
    end else begin
      if (i_m0_gnt)   r_m0_grants <= r_m0_grants + 32'd1;
      if (i_m1_gnt)   r_m1_grants <= r_m1_grants + 32'd1;
      if (i_conflict) r_conflicts <= r_conflicts + 32'd1;
    end
  end

  assign o_m0_grants = r_m0_grants;
  assign o_m1_grants = r_m1_grants;
  assign o_conflicts = r_conflicts;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data memory port: core (m0) has priority,
// debug (m1) wins after MAX_BURST stalls. Stats via DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_m0_grants,
  output logic [31:0]       stat_m1_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  logic [STARVE_W-1:0] r_starve;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                w_sat;
  logic [1:0]          w_own;

  logic              r_m0_rvalid;
  logic [DATA_W-1:0] r_m0_rdata;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_m1_rdata;

  assign w_sat = (r_starve == STARVE_W'(MAX_BURST));

  // Pick the owner; reset blocks every grant immediately.
  always_comb begin
    w_own = OWN_NONE;
    if (rst_n) begin
      unique case (1'b1)
        (m0_req && m1_req): w_own = w_sat ? OWN_M1 : OWN_M0;
        (m0_req && !m1_req): w_own = OWN_M0;
        (!m0_req && m1_req): w_own = OWN_M1;
        default: w_own = OWN_NONE;
      endcase
    end
  end

  assign m0_gnt = (w_own == OWN_M0);
  assign m1_gnt = (w_own == OWN_M1);
  assign mem_ce = m0_gnt | m1_gnt;

  // Route the granted master onto the memory port, zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (w_own)
      OWN_M0: begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      OWN_M1: begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  // Count m0 wins while m1 waits, saturating at the burst bound.
  always_comb begin
    w_starve_nxt = r_starve;
    if (m1_gnt || !m1_req)
      w_starve_nxt = '0;
    else if (m0_gnt && !w_sat)
      w_starve_nxt = r_starve + STARVE_W'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve <= '0;
    else        r_starve <= w_starve_nxt;
  end

  // Capture read data at the end of a read grant; pulse rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rvalid <= 1'b0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= m0_gnt & ~m0_we;
      r_m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) r_m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) r_m1_rdata <= mem_rdata;
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rvalid = r_m1_rvalid;
  assign m1_rdata  = r_m1_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic w_conflict;
  assign w_conflict = m0_req & m1_req;

  dmem_arb_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_m0_gnt    (m0_gnt),
    .i_m1_gnt    (m1_gnt),
    .i_conflict  (w_conflict),
    .o_m0_grants (stat_m0_grants),
    .o_m1_grants (stat_m1_grants),
    .o_conflicts (stat_conflicts)
  );
`endif

endmodule
